ps2_key_event_decoder: RTL and testbench
========================================

# ps2_key_event_decoder

Parametrised successor to the single-register keyboard decoder. Consumes the byte stream from `ps2_keyboard` and parses make/break/extended/pause scancode sequences into 16-bit key events. Tracks modifier state, optionally suppresses typematic repeats, and buffers events in a FIFO with a valid/ready output toward the CPU/MMIO side. Sits between `ps2_keyboard` and the keyboard MMIO register file.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `SUPPRESS_REPEAT`, 1: 1 = drop repeated makes of the currently held key.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `kb_data_i` in 8: byte from `ps2_keyboard` (`keydata`).
- `kb_ready_i` in 1: byte available (`ready`).
- `kb_overflow_i` in 1: `ps2_keyboard` overflow flag.
- `kb_nextdata_n_o` out 1: active-low byte acknowledge to `ps2_keyboard`.
- `evt_valid_o` out 1: FIFO head valid.
- `evt_ready_i` in 1: consumer pops the head when `evt_valid_o && evt_ready_i`.
- `evt_data_o` out 16: head event. Fields:
  - [15:12] mods {caps, alt, ctrl, shift}
  - [11] pause
  - [10] ext
  - [9] release
  - [8] 0
  - [7:0] code
- `evt_count_o` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `mods_o` out 4: live {caps, alt, ctrl, shift}.
- `drop_cnt_o` out 8: dropped-event count, saturates at 255.

## Operation
- Byte consume: in any cycle with `kb_ready_i=1 && kb_nextdata_n_o=1`, the byte is consumed.
  - `kb_nextdata_n_o` goes 0 for exactly the next cycle, then returns to 1.
  - At most one byte is consumed per two cycles.
- Parser FSM states: IDLE, PFX (prefix seen), PAUSE.
  - Prefix flags `ext`/`rel` are held in PFX.
  - IDLE/PFX on E0: set `ext`, go to PFX.
  - IDLE/PFX on F0: set `rel`, go to PFX.
  - IDLE on E1: load the pause counter with 7, go to PAUSE.
  - IDLE on AA, FA, EE, FE, 00 or FF: ignored, no event.
  - IDLE/PFX on any other byte: emit event {ext, rel, code}, clear flags, go to IDLE.
  - PFX on E1, or on AA/FA/EE/FE/00/FF: clear flags, go to IDLE, no event.
  - PAUSE: each consumed byte decrements the counter. At 0, emit event with pause=1, code=0x00, ext=0, release=0, then go to IDLE.
- Modifiers are updated before the mods snapshot is taken; the event carries the post-update value.
  - shift = held(0x12) | held(0x59).
  - ctrl = held(0x14) | held(E0 0x14).
  - alt = held(0x11) | held(E0 0x11).
  - caps toggles on the first make of 0x58 only; its repeats do not toggle.
  - Modifier tracking is unaffected by repeat suppression.
- Repeat suppression (SUPPRESS_REPEAT=1):
  - A `last_make` register holds {ext, code} of the most recent make.
  - A make equal to `last_make` is dropped silently; it does not count in `drop_cnt`.
  - A break matching `last_make` clears it.
- FIFO:
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the event is dropped and `drop_cnt_o` increments.
  - Pop when empty has no effect.
- Overflow: a rising edge of `kb_overflow_i` forces the parser to IDLE, clears the flags, and increments `drop_cnt_o`. FIFO and modifiers are kept.

## Timing
- Reset values:
  - `kb_nextdata_n_o=1`
  - `evt_valid_o=0`
  - `evt_data_o=0`
  - `evt_count_o=0`
  - `mods_o=0`
  - `drop_cnt_o=0`
  - FSM in IDLE, flags, `last_make` and held-modifier bits cleared.
- Reset mid-sequence discards partial prefixes and all FIFO contents.
- Latency: final byte consumed at edge N → `mods_o` updated at N+1; event visible at the FIFO head at N+1 if the FIFO was empty.
- `evt_data_o` is registered and stable while `evt_valid_o=1 && !evt_ready_i`.
- Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.
- `drop_cnt_o` increments at most once per cycle. If overflow and FIFO-full drop coincide, it increments by one only.

## Structure
- Package `ps2_pkg`:
  - Event field index localparams.
  - Parser state enum.
  - Scancode constants: E0, F0, E1, AA, FA, EE, FE, 12, 59, 14, 11, 58.
  - Event struct typedef.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; push/pop/full/empty/count), instantiated once with WIDTH=16.
- Parser, modifier tracker and repeat filter live in the top module.

## Test plan
- Bytes 1C, F0 1C (DEPTH=8) → events 0x001C then 0x021C; `kb_nextdata_n_o` low exactly one cycle after each byte.
- E0 75, E0 F0 75 → 0x0475 then 0x0675.
- 12, 1C, 1C, 1C, F0 1C, F0 12 with SUPPRESS_REPEAT=1 → events 0x1012, 0x101C, 0x121C, 0x0212; `mods_o` shift=1 between, 0 after. With SUPPRESS_REPEAT=0 → two extra 0x101C.
- 58, F0 58, 58 → caps 1, 1, 0; events 0x8058, 0x8258, 0x0058.
- E1 14 77 E1 F0 14 F0 77 → single event 0x0800; no spurious 0x14/0x77 events; ctrl stays 0.
- 10 makes with `evt_ready_i=0`, DEPTH=8 → `evt_count_o`=8, `drop_cnt_o`=2. Pop on the cycle a push arrives while full → push accepted, count stays 8. `rst` mid `E0 F0` → next byte 1C yields 0x001C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Event word layout: [15:12] mods {caps, alt, ctrl, shift}, [11] pause,
// [10] ext, [9] release, [8] reserved (0), [7:0] code.
package ps2_pkg;

    localparam int EVT_W         = 16;
    localparam int EVT_MODS_LSB  = 12;
    localparam int EVT_PAUSE_BIT = 11;
    localparam int EVT_EXT_BIT   = 10;
    localparam int EVT_REL_BIT   = 9;
    localparam int EVT_CODE_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PFX   = 2'd1,
        ST_PAUSE = 2'd2
    } parse_state_t;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_AA     = 8'hAA;
    localparam logic [7:0] SC_FA     = 8'hFA;
    localparam logic [7:0] SC_EE     = 8'hEE;
    localparam logic [7:0] SC_FE     = 8'hFE;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef struct packed {
        logic [3:0] mods;
        logic       pause;
        logic       ext;
        logic       rel;
        logic       rsvd;
        logic [7:0] code;
    } key_evt_t;

    // Keyboard status/response bytes that never form part of a key code.
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == SC_AA) || (b == SC_FA) || (b == SC_EE) ||
               (b == SC_FE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, register-array storage, head shown combinationally from the array.
// Latency: a push is visible at pop_dat the cycle after it is written into an empty FIFO.
// Backpressure: push is accepted when not full, or when full with a pop in the same cycle; else ignored.
//
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat,
// full, empty, count (0..DEPTH). pop_dat reads 0 while empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    // When full, wr_ptr == rd_ptr: the pop frees exactly the slot being written.
    assign wr_en = push && (!full || rd_en);

    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Parses PS/2 scancode bytes (make/break/E0/E1 pause) into 16-bit key events with modifier snapshot.
// Latency: byte consumed at edge N -> mods_o and FIFO head updated at edge N+1.
// Backpressure: events queue in a FIFO (valid/ready out); a push into a full FIFO is dropped and counted.
//
// Ports: clk, rst (sync, active-high); kb_data_i/kb_ready_i/kb_overflow_i and
// kb_nextdata_n_o (active-low ack) toward ps2_keyboard; evt_valid_o/evt_ready_i/
// evt_data_o/evt_count_o toward the consumer; mods_o live modifiers; drop_cnt_o.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   kb_data_i,
    input  logic                         kb_ready_i,
    input  logic                         kb_overflow_i,
    output logic                         kb_nextdata_n_o,
    output logic                         evt_valid_o,
    input  logic                         evt_ready_i,
    output logic [EVT_W-1:0]             evt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]  evt_count_o,
    output logic [3:0]                   mods_o,
    output logic [7:0]                   drop_cnt_o
);

    // ---------------- byte handshake and overflow edge ----------------
    logic consume;
    logic ovf_q;
    logic ovf_edge;

    // The ack register itself blocks back-to-back consumes: one byte per two cycles.
    assign consume  = kb_ready_i && kb_nextdata_n_o;
    assign ovf_edge = kb_overflow_i && !ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            kb_nextdata_n_o <= 1'b1;
            ovf_q           <= 1'b0;
        end else begin
            kb_nextdata_n_o <= !consume;
            ovf_q           <= kb_overflow_i;
        end
    end

    // ---------------- parser FSM ----------------
    parse_state_t state;
    logic         ext_q;
    logic         rel_q;
    logic [2:0]   pcnt_q;
    // Registered parser output: a completed key sequence waiting for the modifier stage.
    logic         pend_vld;
    logic         pend_pause;
    logic         pend_ext;
    logic         pend_rel;
    logic [7:0]   pend_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            pcnt_q     <= 3'd0;
            pend_vld   <= 1'b0;
            pend_pause <= 1'b0;
            pend_ext   <= 1'b0;
            pend_rel   <= 1'b0;
            pend_code  <= 8'h00;
        end else begin
            pend_vld <= 1'b0;
            if (ovf_edge) begin
                // Stream lost sync: drop any partial sequence and this cycle's byte.
                state <= ST_IDLE;
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (consume) begin
                case (state)
                    ST_PAUSE: begin
                        pcnt_q <= pcnt_q - 3'd1;
                        if (pcnt_q == 3'd1) begin
                            pend_vld   <= 1'b1;
                            pend_pause <= 1'b1;
                            pend_ext   <= 1'b0;
                            pend_rel   <= 1'b0;
                            pend_code  <= 8'h00;
                            state      <= ST_IDLE;
                        end
                    end
                    ST_IDLE, ST_PFX: begin
                        if (kb_data_i == SC_E0) begin
                            ext_q <= 1'b1;
                            state <= ST_PFX;
                        end else if (kb_data_i == SC_F0) begin
                            rel_q <= 1'b1;
                            state <= ST_PFX;
                        end else if (kb_data_i == SC_E1 && state == ST_IDLE) begin
                            // Pause sends E1 followed by seven more bytes.
                            pcnt_q <= 3'd7;
                            state  <= ST_PAUSE;
                        end else begin
                            ext_q <= 1'b0;
                            rel_q <= 1'b0;
                            state <= ST_IDLE;
                            // E1 after a prefix, or a status byte, ends the sequence silently.
                            if (kb_data_i != SC_E1 && !is_status_byte(kb_data_i)) begin
                                pend_vld   <= 1'b1;
                                pend_pause <= 1'b0;
                                pend_ext   <= ext_q;
                                pend_rel   <= rel_q;
                                pend_code  <= kb_data_i;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        ext_q <= 1'b0;
                        rel_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- modifier tracker ----------------
    logic       lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;
    logic       caps_q, caps_held_q;
    logic       nxt_lshift, nxt_rshift, nxt_lctrl, nxt_rctrl, nxt_lalt, nxt_ralt;
    logic       nxt_caps, nxt_caps_held;
    logic [3:0] nxt_mods;
    logic       key_evt;
    logic [8:0] key_id;

    assign key_evt = pend_vld && !pend_pause;
    assign key_id  = {pend_ext, pend_code};

    always_comb begin
        nxt_lshift    = lshift_q;
        nxt_rshift    = rshift_q;
        nxt_lctrl     = lctrl_q;
        nxt_rctrl     = rctrl_q;
        nxt_lalt      = lalt_q;
        nxt_ralt      = ralt_q;
        nxt_caps      = caps_q;
        nxt_caps_held = caps_held_q;
        if (key_evt) begin
            case (key_id)
                {1'b0, SC_LSHIFT}: nxt_lshift = !pend_rel;
                {1'b0, SC_RSHIFT}: nxt_rshift = !pend_rel;
                {1'b0, SC_CTRL}:   nxt_lctrl  = !pend_rel;
                {1'b1, SC_CTRL}:   nxt_rctrl  = !pend_rel;
                {1'b0, SC_ALT}:    nxt_lalt   = !pend_rel;
                {1'b1, SC_ALT}:    nxt_ralt   = !pend_rel;
                {1'b0, SC_CAPS}: begin
                    // Typematic repeats of a held Caps Lock must not toggle it again.
                    if (!pend_rel && !caps_held_q) begin
                        nxt_caps = !caps_q;
                    end
                    nxt_caps_held = !pend_rel;
                end
                default: ;
            endcase
        end
    end

    assign nxt_mods = {nxt_caps, nxt_lalt | nxt_ralt, nxt_lctrl | nxt_rctrl, nxt_lshift | nxt_rshift};

    always_ff @(posedge clk) begin
        if (rst) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            mods_o      <= 4'h0;
        end else begin
            lshift_q    <= nxt_lshift;
            rshift_q    <= nxt_rshift;
            lctrl_q     <= nxt_lctrl;
            rctrl_q     <= nxt_rctrl;
            lalt_q      <= nxt_lalt;
            ralt_q      <= nxt_ralt;
            caps_q      <= nxt_caps;
            caps_held_q <= nxt_caps_held;
            mods_o      <= nxt_mods;
        end
    end

    // ---------------- repeat filter ----------------
    logic [8:0] last_make_q;
    logic       is_make;
    logic       is_rpt;

    // {ext=0, code=00} never forms a make, so zero doubles as "no key held".
    assign is_make = key_evt && !pend_rel;
    assign is_rpt  = SUPPRESS_REPEAT && is_make && (key_id == last_make_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_make_q <= 9'h000;
        end else if (SUPPRESS_REPEAT) begin
            if (is_make && !is_rpt) begin
                last_make_q <= key_id;
            end else if (key_evt && pend_rel && key_id == last_make_q) begin
                last_make_q <= 9'h000;
            end
        end
    end

    // ---------------- event FIFO and drop accounting ----------------
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_drop;
    logic             drop_inc;
    logic [EVT_W-1:0] push_dat;

    assign push = pend_vld && !is_rpt;
    assign pop  = evt_valid_o && evt_ready_i;

    always_comb begin
        push_dat                         = '0;
        push_dat[EVT_MODS_LSB +: 4]      = nxt_mods;
        push_dat[EVT_PAUSE_BIT]          = pend_pause;
        push_dat[EVT_EXT_BIT]            = pend_ext;
        push_dat[EVT_REL_BIT]            = pend_rel;
        push_dat[EVT_CODE_LSB +: 8]      = pend_code;
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (evt_data_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (evt_count_o)
    );

    assign evt_valid_o = !fifo_empty;
    assign push_drop   = push && fifo_full && !pop;
    // Overflow and a full-FIFO drop in the same cycle count as one loss.
    assign drop_inc    = ovf_edge || push_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o <= 8'h00;
        end else if (drop_inc && drop_cnt_o != 8'hFF) begin
            drop_cnt_o <= drop_cnt_o + 8'h01;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
module tb_ps2_key_event_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_ovf;
    logic       evt_ready;

    logic        nd_a, vld_a, nd_b, vld_b;
    logic [15:0] dat_a, dat_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [3:0]  mods_a, mods_b;
    logic [7:0]  drop_a, drop_b;

    ps2_key_event_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b1)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .kb_data_i       (kb_data),
        .kb_ready_i      (kb_ready),
        .kb_overflow_i   (kb_ovf),
        .kb_nextdata_n_o (nd_a),
        .evt_valid_o     (vld_a),
        .evt_ready_i     (evt_ready),
        .evt_data_o      (dat_a),
        .evt_count_o     (cnt_a),
        .mods_o          (mods_a),
        .drop_cnt_o      (drop_a)
    );

    ps2_key_event_decoder #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1'b0)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .kb_data_i       (kb_data),
        .kb_ready_i      (kb_ready),
        .kb_overflow_i   (kb_ovf),
        .kb_nextdata_n_o (nd_b),
        .evt_valid_o     (vld_b),
        .evt_ready_i     (evt_ready),
        .evt_data_o      (dat_b),
        .evt_count_o     (cnt_b),
        .mods_o          (mods_b),
        .drop_cnt_o      (drop_b)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_both(input logic [15:0] e);
        exp_a.push_back(e);
        exp_b.push_back(e);
    endtask

    // Scoreboard monitor: compares every popped head against the expected queues.
    always @(negedge clk) begin
        if (!rst && evt_ready) begin
            if (vld_a) begin
                if (exp_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL evt_a: got %0h want no event", dat_a);
                end else begin
                    chk("evt_a", dat_a, exp_a.pop_front());
                end
            end
            if (vld_b) begin
                if (exp_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL evt_b: got %0h want no event", dat_b);
                end else begin
                    chk("evt_b", dat_b, exp_b.pop_front());
                end
            end
        end
    end

    // Presents one byte, waits for it to be consumed, and checks the one-cycle ack pulse.
    task automatic send_byte(input logic [7:0] b, input bit chk_lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (nd_a !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            total++; bad++;
            $display("FAIL ack_wait: got nextdata_n=%0b want 1", nd_a);
        end
        kb_data  = b;
        kb_ready = 1'b1;
        @(negedge clk);
        kb_ready = 1'b0;
        chk("ack_low_a", nd_a, 1'b0);
        chk("ack_low_b", nd_b, 1'b0);
        if (chk_lat) chk("lat_early", vld_a, 1'b0);
        @(negedge clk);
        chk("ack_high", nd_a, 1'b1);
        if (chk_lat) chk("lat_head", vld_a, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] codes [10];
        codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
        rst = 1'b1; kb_data = 8'h00; kb_ready = 1'b0; kb_ovf = 1'b0; evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_nd", nd_a, 1'b1);
        chk("rst_vld", vld_a, 1'b0);
        chk("rst_dat", dat_a, 16'h0000);
        chk("rst_cnt", cnt_a, 4'd0);
        chk("rst_mods", mods_a, 4'h0);
        chk("rst_drop", drop_a, 8'd0);

        // Plain make then break.
        push_both(16'h001C); push_both(16'h021C);
        send_byte(8'h1C, 1'b1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b1);

        // Extended make / break.
        push_both(16'h0475); push_both(16'h0675);
        send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);

        // Shift held over typematic repeats; dut_b keeps the repeats.
        exp_a.push_back(16'h1012); exp_a.push_back(16'h101C);
        exp_a.push_back(16'h121C); exp_a.push_back(16'h0212);
        exp_b.push_back(16'h1012); exp_b.push_back(16'h101C); exp_b.push_back(16'h101C);
        exp_b.push_back(16'h101C); exp_b.push_back(16'h121C); exp_b.push_back(16'h0212);
        send_byte(8'h12, 1'b0);
        chk("shift_on", mods_a, 4'h1);
        send_byte(8'h1C, 1'b0); send_byte(8'h1C, 1'b0); send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
        chk("shift_held", mods_a, 4'h1);
        send_byte(8'hF0, 1'b0); send_byte(8'h12, 1'b0);
        chk("shift_off_a", mods_a, 4'h0);
        chk("shift_off_b", mods_b, 4'h0);

        // Caps Lock toggling on make only.
        push_both(16'h8058); push_both(16'h8258); push_both(16'h0058); push_both(16'h0258);
        send_byte(8'h58, 1'b0);
        chk("caps_1", mods_a, 4'h8);
        send_byte(8'hF0, 1'b0); send_byte(8'h58, 1'b0);
        chk("caps_2", mods_a, 4'h8);
        send_byte(8'h58, 1'b0);
        chk("caps_3", mods_a, 4'h0);
        send_byte(8'hF0, 1'b0); send_byte(8'h58, 1'b0);
        chk("caps_4_b", mods_b, 4'h0);

        // Pause sequence produces one event and never touches ctrl.
        push_both(16'h0800);
        send_byte(8'hE1, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h77, 1'b0);
        chk("pause_mods", mods_a, 4'h0);
        repeat (4) @(negedge clk);

        // Fill past capacity with the consumer stalled.
        @(posedge clk); #1 evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) push_both({8'h00, codes[i]});
            send_byte(codes[i], 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("full_cnt_a", cnt_a, 4'd8);
        chk("full_drop_a", drop_a, 8'd2);
        chk("full_cnt_b", cnt_b, 4'd8);
        chk("full_drop_b", drop_b, 8'd2);

        // Pop in exactly the cycle a push lands on the full FIFO.
        kb_data = 8'h4B; kb_ready = 1'b1;
        @(posedge clk); #1 kb_ready = 1'b0; evt_ready = 1'b1;
        push_both(16'h004B);
        @(posedge clk); #1 evt_ready = 1'b0;
        @(negedge clk);
        chk("poppush_cnt", cnt_a, 4'd8);
        chk("poppush_drop", drop_a, 8'd2);
        @(posedge clk); #1 evt_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("drain_cnt", cnt_a, 4'd0);

        // Overflow pulse cancels a pending E0 prefix and counts as a drop.
        send_byte(8'hE0, 1'b0);
        @(negedge clk); kb_ovf = 1'b1;
        @(negedge clk); kb_ovf = 1'b0;
        push_both(16'h001C);
        send_byte(8'h1C, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovf_drop_a", drop_a, 8'd3);
        chk("ovf_drop_b", drop_b, 8'd3);

        // Reset in the middle of E0 F0 discards the prefix and the last-make memory.
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst2_drop", drop_a, 8'd0);
        chk("rst2_cnt", cnt_a, 4'd0);
        chk("rst2_nd", nd_a, 1'b1);
        push_both(16'h001C);
        send_byte(8'h1C, 1'b0);
        repeat (4) @(negedge clk);

        chk("leftover_a", exp_a.size(), 0);
        chk("leftover_b", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
